// File: rtl/bnn_pkg.sv
// bnn_pkg: constants, loader state encoding and sizing helper shared by the loader and conv core
package bnn_pkg;

    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        LOAD_W,
        LOAD_PIX,
        HOLD
    } loader_state_t;

    function automatic int npix(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: assembles one kernel plus one binary frame from a beat stream and holds it for the conv core
module conv_frame_loader
    import bnn_pkg::*;
#(
    parameter int IC = 8,
    parameter int IMG_IN_SIZE = 30,
    localparam int NPIX = npix(IMG_IN_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [IC-1:0]               s_data,
    input  logic                        s_last,
    output logic [NPIX-1:0]             img_in [0:IC-1],
    output logic [IC*KERNEL_TAPS-1:0]   weights,
    output logic                        frame_valid,
    input  logic                        frame_ack,
    output logic                        frame_err
);

    // the counter also walks the 9 weight taps, so it never gets narrower than 4 bits
    localparam int CW = ($clog2(NPIX) > 4) ? $clog2(NPIX) : 4;

    loader_state_t              state_q;
    logic [CW-1:0]              cnt_q;
    logic [NPIX-1:0]            img_q [0:IC-1];
    logic [IC*KERNEL_TAPS-1:0]  weights_q;
    logic                       valid_q;
    logic                       err_q;
    logic [KERNEL_TAPS-1:0]     wsel;
    logic [NPIX-1:0]            psel;
    logic                       last_pix;

    always_comb begin
        wsel     = KERNEL_TAPS'(1) << cnt_q;
        psel     = NPIX'(1) << cnt_q;
        last_pix = cnt_q == CW'(NPIX - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD_W;
            cnt_q     <= '0;
            weights_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < IC; i++) img_q[i] <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                LOAD_W: if (s_valid) begin
                    for (int i = 0; i < IC; i++)
                        weights_q[i*KERNEL_TAPS +: KERNEL_TAPS] <= s_data[i]
                            ? (weights_q[i*KERNEL_TAPS +: KERNEL_TAPS] | wsel)
                            : (weights_q[i*KERNEL_TAPS +: KERNEL_TAPS] & ~wsel);
                    if (s_last) begin
                        err_q <= 1'b1;
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(KERNEL_TAPS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= LOAD_PIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOAD_PIX: if (s_valid) begin
                    for (int i = 0; i < IC; i++)
                        img_q[i] <= s_data[i] ? (img_q[i] | psel) : (img_q[i] & ~psel);
                    // s_last must coincide exactly with the final raster pixel
                    if (s_last != last_pix) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= LOAD_W;
                    end else if (last_pix) begin
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: if (frame_ack) begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= LOAD_W;
                end
                default: state_q <= LOAD_W;
            endcase
        end
    end

    assign s_ready     = state_q != HOLD;
    assign weights     = weights_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign img_in      = img_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// tb_conv_frame_loader: directed scoreboard bench for the frame loader, small and default geometries
module tb_conv_frame_loader;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_last, frame_ack;
    logic [1:0]  s_data;
    logic        s_ready, frame_valid, frame_err;
    logic [15:0] img_in [0:1];
    logic [17:0] weights;

    logic         b_valid, b_last, b_ack;
    logic [7:0]   b_data;
    logic         b_ready, b_fv, b_err;
    logic [899:0] b_img [0:7];
    logic [71:0]  b_w;

    int errors = 0;
    int checks = 0;
    bit gaps = 0;

    typedef struct {
        logic [17:0] w;
        logic [15:0] i0;
        logic [15:0] i1;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    conv_frame_loader #(.IC(2), .IMG_IN_SIZE(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .img_in(img_in), .weights(weights), .frame_valid(frame_valid),
        .frame_ack(frame_ack), .frame_err(frame_err)
    );

    conv_frame_loader dut_big (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_last(b_last), .img_in(b_img), .weights(b_w), .frame_valid(b_fv),
        .frame_ack(b_ack), .frame_err(b_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic [1:0] d, input logic l);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 1)) begin
            s_valid   = 1'b0;
            s_data    = 2'($urandom);
            s_last    = 1'($urandom);
            frame_ack = 1'($urandom);
            @(posedge clk); #1;
            frame_ack = 1'b0;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) chk("beat_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [17:0] w, input logic [15:0] i0, input logic [15:0] i1);
        exp_t e;
        for (int k = 0; k < 9; k++) beat({w[9+k], w[k]}, 1'b0);
        e.w = w; e.i0 = i0; e.i1 = i1;
        sb.push_back(e);
        for (int p = 0; p < 16; p++) beat({i1[p], i0[p]}, p == 15);
    endtask

    task automatic send_prefix(input int npx);
        for (int k = 0; k < 9; k++) beat(2'($urandom), 1'b0);
        for (int p = 0; p < npx; p++) beat(2'($urandom), 1'b0);
    endtask

    task automatic send_random_frame();
        send_frame(18'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_valid"}, frame_valid, 1);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({tag, "_weights"}, weights, cur.w);
            chk({tag, "_img0"}, img_in[0], cur.i0);
            chk({tag, "_img1"}, img_in[1], cur.i1);
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        chk("ack_valid_low", frame_valid, 0);
        chk("ack_ready_high", s_ready, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, s_ready, 1);
        chk({tag, "_valid"}, frame_valid, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_weights"}, weights, 0);
        chk({tag, "_img0"}, img_in[0], 0);
        chk({tag, "_img1"}, img_in[1], 0);
    endtask

    logic [899:0] bexp [0:7];
    logic [71:0]  bwexp;

    initial begin
        rst = 1'b1; s_valid = 0; s_last = 0; s_data = 0; frame_ack = 0;
        b_valid = 0; b_last = 0; b_data = 0; b_ack = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // scenario 1: fixed pattern with known result
        for (int k = 0; k < 9; k++) beat(2'b01, 1'b0);
        cur.w = 18'h001FF; cur.i0 = 16'hAAAA; cur.i1 = 16'hCCCC;
        sb.push_back(cur);
        for (int p = 0; p < 15; p++) beat(2'(p), 1'b0);
        chk("s1_valid_before_last", frame_valid, 0);
        beat(2'(15), 1'b1);
        check_frame("s1");

        // scenario 2: stall in HOLD, then ack and reload back-to-back
        s_valid = 1'b1;
        s_data  = 2'b11;
        s_last  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("s2_ready_low", s_ready, 0);
            chk("s2_valid_held", frame_valid, 1);
            chk("s2_weights_held", weights, cur.w);
            chk("s2_img1_held", img_in[1], cur.i1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        ack();
        send_random_frame();
        check_frame("s2");
        ack();

        // scenario 3: early s_last on pixel 7
        send_prefix(7);
        beat(2'b10, 1'b1);
        chk("s3_err_pulse", frame_err, 1);
        @(posedge clk); #1;
        chk("s3_err_cleared", frame_err, 0);
        chk("s3_no_valid", frame_valid, 0);
        send_random_frame();
        check_frame("s3");
        ack();

        // scenario 4: missing s_last on pixel 15
        send_prefix(15);
        beat(2'b01, 1'b0);
        chk("s4_err_pulse", frame_err, 1);
        chk("s4_no_valid", frame_valid, 0);
        @(posedge clk); #1;
        chk("s4_err_cleared", frame_err, 0);
        chk("s4_still_no_valid", frame_valid, 0);

        // scenario 5: random gaps with stray acks while loading
        gaps = 1;
        send_random_frame();
        gaps = 0;
        check_frame("s5");
        ack();

        // scenario 6: reset mid-frame at pixel 9
        send_prefix(9);
        s_valid = 1'b1;
        s_data  = 2'b11;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        check_reset_state("s6");
        send_random_frame();
        check_frame("s6");
        ack();

        // default geometry: 909 beats
        for (int k = 0; k < 9; k++) begin
            b_valid = 1'b1;
            b_data  = 8'($urandom);
            for (int i = 0; i < 8; i++) bwexp[i*9+k] = b_data[i];
            @(posedge clk); #1;
        end
        for (int p = 0; p < 900; p++) begin
            b_data = 8'($urandom);
            b_last = (p == 899);
            for (int i = 0; i < 8; i++) bexp[i][p] = b_data[i];
            if (p == 899) chk("big_valid_before_last", b_fv, 0);
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        chk("big_valid", b_fv, 1);
        chk("big_err", b_err, 0);
        chk("big_ready_low", b_ready, 0);
        chk("big_weights_diff", 64'($countones(b_w ^ bwexp)), 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("big_img%0d_diff", i), 64'($countones(b_img[i] ^ bexp[i])), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
